// File: rtl/mips_pkg.sv
// Shared MIPS controller constants: opcodes, datapath mux encodings and FSM state encoding.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_LOGIC = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_FETCH    = 4'd1;
  localparam logic [3:0] ST_DECODE   = 4'd2;
  localparam logic [3:0] ST_R_EXEC   = 4'd3;
  localparam logic [3:0] ST_R_WB     = 4'd4;
  localparam logic [3:0] ST_I_EXEC   = 4'd5;
  localparam logic [3:0] ST_I_WB     = 4'd6;
  localparam logic [3:0] ST_MEM_ADDR = 4'd7;
  localparam logic [3:0] ST_MEM_RD   = 4'd8;
  localparam logic [3:0] ST_MEM_WR   = 4'd9;
  localparam logic [3:0] ST_MEM_WB   = 4'd10;
  localparam logic [3:0] ST_BRANCH   = 4'd11;
  localparam logic [3:0] ST_JUMP     = 4'd12;

  typedef enum logic [3:0] {
    S_IDLE     = ST_IDLE,
    S_FETCH    = ST_FETCH,
    S_DECODE   = ST_DECODE,
    S_R_EXEC   = ST_R_EXEC,
    S_R_WB     = ST_R_WB,
    S_I_EXEC   = ST_I_EXEC,
    S_I_WB     = ST_I_WB,
    S_MEM_ADDR = ST_MEM_ADDR,
    S_MEM_RD   = ST_MEM_RD,
    S_MEM_WR   = ST_MEM_WR,
    S_MEM_WB   = ST_MEM_WB,
    S_BRANCH   = ST_BRANCH,
    S_JUMP     = ST_JUMP
  } state_e;

  // States that hold a memory access open and therefore count wait cycles.
  function automatic logic is_mem_state(state_e s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory bundle: IR opcode, ALU flag, memory handshake and control lines.
interface multicycle_control_if #(parameter int OPCODE_W = 6);
  logic [OPCODE_W-1:0] Opcode;
  logic                Zero;
  logic                mem_ready;
  logic                mem_req;
  logic                MemRead;
  logic                MemWrite;
  logic                mem_half;
  logic                IorD;
  logic                IRWrite;
  logic                PCWrite;
  logic                PCWriteCond;
  logic [1:0]          PCSource;
  logic                ALUSrcA;
  logic [1:0]          ALUSrcB;
  logic [1:0]          ALUOp;
  logic                RegDst;
  logic                MemtoReg;
  logic                RegWrite;
  logic                illegal_op;
  logic                bus_err;

  modport master (
    input  Opcode, Zero, mem_ready,
    output mem_req, MemRead, MemWrite, mem_half, IorD, IRWrite, PCWrite, PCWriteCond,
           PCSource, ALUSrcA, ALUSrcB, ALUOp, RegDst, MemtoReg, RegWrite, illegal_op, bus_err
  );

  modport slave (
    output Opcode, Zero, mem_ready,
    input  mem_req, MemRead, MemWrite, mem_half, IorD, IRWrite, PCWrite, PCWriteCond,
           PCSource, ALUSrcA, ALUSrcB, ALUOp, RegDst, MemtoReg, RegWrite, illegal_op, bus_err
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main controller: Moore FSM sequencing FETCH..WRITEBACK with memory stall,
// bus timeout and illegal-opcode detection.
module multicycle_control
  import mips_pkg::*;
#(
  parameter int OPCODE_W    = 6,
  parameter int TIMEOUT_W   = 8,
  parameter int MEM_TIMEOUT = 255
) (
  input logic                  clk,
  input logic                  rst_n,
  multicycle_control_if.master bus
);

  state_e               state_q, state_d;
  logic [TIMEOUT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                 illegal_op_q, illegal_op_d;
  logic                 bus_err_q, bus_err_d;

  logic [OPCODE_W-1:0]  op;
  logic                 is_half;
  logic                 is_load;
  logic                 waiting;
  logic                 timeout;

  assign op      = bus.Opcode;
  assign is_half = (op == OPCODE_W'(OP_LH)) || (op == OPCODE_W'(OP_SH));
  assign is_load = (op == OPCODE_W'(OP_LW)) || (op == OPCODE_W'(OP_LH));
  assign waiting = is_mem_state(state_q) && !bus.mem_ready;
  // mem_ready on the final allowed cycle is a normal completion, so it masks the timeout.
  assign timeout = waiting && (wait_cnt_q == TIMEOUT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = '0;
    illegal_op_d = illegal_op_q;
    bus_err_d    = bus_err_q;
    if (waiting) wait_cnt_d = wait_cnt_q + 1'b1;
    if (timeout) begin
      bus_err_d  = 1'b1;
      wait_cnt_d = '0;
      state_d    = S_FETCH;
    end else begin
      case (state_q)
        S_IDLE:     state_d = S_FETCH;
        S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
        S_DECODE: begin
          case (op)
            OPCODE_W'(OP_RTYPE):                    state_d = S_R_EXEC;
            OPCODE_W'(OP_ADDI), OPCODE_W'(OP_ANDI),
            OPCODE_W'(OP_ORI):                      state_d = S_I_EXEC;
            OPCODE_W'(OP_LW), OPCODE_W'(OP_LH),
            OPCODE_W'(OP_SW), OPCODE_W'(OP_SH):     state_d = S_MEM_ADDR;
            OPCODE_W'(OP_BEQ):                      state_d = S_BRANCH;
            OPCODE_W'(OP_J):                        state_d = S_JUMP;
            default: begin
              illegal_op_d = 1'b1;
              state_d      = S_FETCH;
            end
          endcase
        end
        S_R_EXEC:   state_d = S_R_WB;
        S_I_EXEC:   state_d = S_I_WB;
        S_MEM_ADDR: state_d = is_load ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   if (bus.mem_ready) state_d = S_MEM_WB;
        S_MEM_WR:   if (bus.mem_ready) state_d = S_FETCH;
        S_R_WB, S_I_WB, S_MEM_WB,
        S_BRANCH, S_JUMP:             state_d = S_FETCH;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wait_cnt_q   <= '0;
      illegal_op_q <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      illegal_op_q <= illegal_op_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign bus.illegal_op = illegal_op_q;
  assign bus.bus_err    = bus_err_q;

  // Moore decode; only the FETCH IR/PC loads look at mem_ready.
  always_comb begin
    bus.mem_req     = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.mem_half    = 1'b0;
    bus.IorD        = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.PCSource    = PC_ALU;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = SRCB_REGB;
    bus.ALUOp       = ALU_ADD;
    bus.RegDst      = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.RegWrite    = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.mem_req = 1'b1;
        bus.MemRead = 1'b1;
        bus.ALUSrcB = SRCB_FOUR;
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
      end
      S_DECODE:   bus.ALUSrcB = SRCB_IMM_SH2;
      S_R_EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = ALU_FUNCT;
      end
      S_R_WB: begin
        bus.RegDst   = 1'b1;
        bus.RegWrite = 1'b1;
      end
      S_I_EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = SRCB_IMM;
        bus.ALUOp   = (op == OPCODE_W'(OP_ADDI)) ? ALU_ADD : ALU_LOGIC;
      end
      S_I_WB:     bus.RegWrite = 1'b1;
      S_MEM_ADDR: begin
        bus.ALUSrcA  = 1'b1;
        bus.ALUSrcB  = SRCB_IMM;
        bus.mem_half = is_half;
      end
      S_MEM_RD: begin
        bus.mem_req  = 1'b1;
        bus.MemRead  = 1'b1;
        bus.IorD     = 1'b1;
        bus.mem_half = is_half;
      end
      S_MEM_WR: begin
        bus.mem_req  = 1'b1;
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
        bus.mem_half = is_half;
      end
      S_MEM_WB: begin
        bus.MemtoReg = 1'b1;
        bus.RegWrite = 1'b1;
        bus.mem_half = is_half;
      end
      S_BRANCH: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUOp       = ALU_SUB;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = PC_ALUOUT;
      end
      S_JUMP: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = PC_JUMP;
      end
      default: ;
    endcase
  end

endmodule
